// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    // Port indices, also used as the value of the last-granted pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-requester winner select with a last-granted pointer (MEM_ARBITER_FIXED_PRIO_EN: port 0 wins ties).
// Latency: winner is combinational; the pointer moves on the edge where take is high.
// Backpressure: none; the caller raises take only on the edge it accepts the winner.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic r,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic winner
);

    logic last;

    // A lone requester always wins; on a tie the port not granted last wins.
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            winner = PORT0;
`else
            winner = (last == PORT0) ? PORT1 : PORT0;
`endif
        end else if (req1) begin
            winner = PORT1;
        end
    end

    // Pointer starts at port 1 so port 0 takes the first tie; frozen in fixed-priority builds.
    always_ff @(posedge clk) begin
        if (r) begin
            last <= PORT1;
        end
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        else if (take) begin
            last <= winner;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter; MEM_ARBITER_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
// Latency: gnt the cycle after req is sampled in IDLE; rvalid one cycle later (2 cycles from sampling edge).
// Backpressure: req is held until gnt; requests are ignored during ACCESS, so at most one access per 2 cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              r,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_rst,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    state_t            state;
    state_t            state_nxt;
    logic              take;
    logic              winner;
    logic              owner;
    logic [DATA_W-1:0] wdata_q;

    mem_arbiter_rr u_rr (
        .clk    (clk),
        .r      (r),
        .req0   (p0_req),
        .req1   (p1_req),
        .take   (take),
        .winner (winner)
    );

    // The RAM shares our reset so both sides clear on the same edge.
    assign ram_rst = r;

    // Bus is driven only during a write cycle; reads leave it to the RAM.
    assign ram_data = ram_we ? wdata_q : {DATA_W{1'bz}};

    // State register.
    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: any request in IDLE starts a one-cycle ACCESS; ACCESS always returns to IDLE.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: launch the winner's access, pulse gnt, and capture read data as ACCESS ends.
    always_ff @(posedge clk) begin
        if (r) begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            owner     <= PORT0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            if (take) begin
                owner    <= winner;
                p0_gnt   <= (winner == PORT0);
                p1_gnt   <= (winner == PORT1);
                ram_addr <= (winner == PORT1) ? p1_addr : p0_addr;
                wdata_q  <= (winner == PORT1) ? p1_wdata : p0_wdata;
                ram_we   <= (winner == PORT1) ? p1_we : p0_we;
                ram_oe   <= (winner == PORT1) ? !p1_we : !p0_we;
            end
            if (state == ACCESS && ram_oe) begin
                if (owner == PORT1) begin
                    p1_rdata  <= ram_data;
                    p1_rvalid <= 1'b1;
                end else begin
                    p0_rdata  <= ram_data;
                    p0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural RAM on the shared bus.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: requests held until the matching grant is observed.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        r;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [23:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic        ram_rst, ram_we, ram_oe;
    logic [23:0] ram_addr;
    wire  [15:0] ram_data;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Behavioural RAM: 64 words, index folds the top address bit with the low five.
    logic [15:0] mem [0:63];
    wire  [5:0]  ram_idx = {ram_addr[23], ram_addr[4:0]};
    wire  [15:0] bus_exp = ram_oe ? mem[ram_idx] : 16'h0000;

    // RAM drives read data while oe, and holds the bus low when idle so a stray DUT driver is visible.
    assign ram_data = ram_we ? 16'hzzzz : bus_exp;

    // RAM write port and reset.
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        end else if (ram_we) begin
            mem[ram_idx] <= ram_data;
        end
    end

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .r(r),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_rst(ram_rst), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    // Every-cycle bus invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ram_we && ram_oe) begin
                errors++;
                $display("FAIL mon_we_oe: got we=%b oe=%b, required not both high", ram_we, ram_oe);
            end
            checks++;
            if (!ram_we && ram_data !== bus_exp) begin
                errors++;
                $display("FAIL mon_bus_release: got %h, required %h (DUT must not drive)", ram_data, bus_exp);
            end
            checks++;
            if ((p0_gnt && p1_gnt) || (p0_rvalid && p1_rvalid)) begin
                errors++;
                $display("FAIL mon_overlap: got gnt=%b%b rvalid=%b%b, required no pair high",
                         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        r = 1'b1;
        tick();
        tick();
        r = 1'b0;
    endtask

    task automatic test_reset;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        r = 1'b1;
        tick();
        tick();
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we, ram_oe} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we, ram_oe});
        end
        checks++;
        if (ram_addr !== 24'h000000) begin
            errors++;
            $display("FAIL reset_addr: got %h, required 000000", ram_addr);
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h, required 0000/0000", p0_rdata, p1_rdata);
        end
        checks++;
        if (ram_rst !== 1'b1 || ram_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ram: got rst=%b data=%h, required 1/0000", ram_rst, ram_data);
        end
        r = 1'b0;
        tick();
        checks++;
        if (ram_rst !== 1'b0 || {p0_gnt, p1_gnt, ram_we, ram_oe} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: got rst=%b ctrl=%b, required 0/0000",
                     ram_rst, {p0_gnt, p1_gnt, ram_we, ram_oe});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write_read;
        p0_req = 1; p0_we = 1; p0_addr = 24'h000010; p0_wdata = 16'hBEEF;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt, ram_we, ram_oe} !== 4'b1010 || ram_addr !== 24'h000010 || ram_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_launch: got ctrl=%b addr=%h data=%h, required 1010/000010/BEEF",
                     {p0_gnt, p1_gnt, ram_we, ram_oe}, ram_addr, ram_data);
        end
        p0_req = 0;
        tick();
        checks++;
        if ({p0_gnt, ram_we, ram_oe, p0_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL wr_end: got gnt/we/oe/rvalid=%b, required 0000", {p0_gnt, ram_we, ram_oe, p0_rvalid});
        end
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        tick();
        checks++;
        if ({p0_gnt, ram_we, ram_oe, p0_rvalid} !== 4'b1010 || ram_addr !== 24'h000010) begin
            errors++;
            $display("FAIL rd_launch: got gnt/we/oe/rvalid=%b addr=%h, required 1010/000010",
                     {p0_gnt, ram_we, ram_oe, p0_rvalid}, ram_addr);
        end
        p0_req = 0;
        tick();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF || p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got rvalid=%b rdata=%h, required 1/BEEF", p0_rvalid, p0_rdata);
        end
        tick();
        checks++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 16'hBEEF || ram_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold: got rvalid=%b rdata=%h oe=%b, required 0/BEEF/0", p0_rvalid, p0_rdata, ram_oe);
        end
    endtask

    task automatic test_simul_read;
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        p1_req = 1; p1_we = 0; p1_addr = 24'h000004;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first: got gnt=%b%b, required 10", p0_gnt, p1_gnt);
        end
        p0_req = 0;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid} !== 3'b001 || p0_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL tie_gap: got gnt=%b%b rvalid0=%b rdata0=%h, required 00/1/0000",
                     p0_gnt, p1_gnt, p0_rvalid, p0_rdata);
        end
        tick();
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || ram_addr !== 24'h000004) begin
            errors++;
            $display("FAIL tie_second: got gnt=%b%b addr=%h, required 01/000004", p0_gnt, p1_gnt, ram_addr);
        end
        p1_req = 0;
        tick();
        checks++;
        if ({p0_rvalid, p1_rvalid} !== 2'b01) begin
            errors++;
            $display("FAIL tie_rvalid: got rvalid=%b%b, required 01", p0_rvalid, p1_rvalid);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] seq;
        logic [7:0] exp_seq;
        int n;
        int gap;
        int bad_gap;
        seq = '0; n = 0; gap = 0; bad_gap = 0;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        exp_seq = 8'b0000_0000;
`else
        exp_seq = 8'b1010_1010;
`endif
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        p1_req = 1; p1_we = 0; p1_addr = 24'h000004;
        for (int c = 0; c < 40 && n < 8; c++) begin
            tick();
            gap++;
            if (p0_gnt || p1_gnt) begin
                seq[n] = p1_gnt;
                if (n > 0 && gap != 2) bad_gap++;
                gap = 0;
                n++;
            end
        end
        p0_req = 0; p1_req = 0;
        tick();
        tick();
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d grants in budget, required 8", n);
        end
        checks++;
        if (seq !== exp_seq) begin
            errors++;
            $display("FAIL rr_order: got p1-bits %b (grant0 in LSB), required %b", seq, exp_seq);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL rr_spacing: got %0d grants not 2 cycles apart, required 0", bad_gap);
        end
    endtask

    task automatic test_p1_write_max;
        p1_req = 1; p1_we = 1; p1_addr = 24'hFFFFFF; p1_wdata = 16'h1234;
        tick();
        checks++;
        if ({p1_gnt, p0_gnt, ram_we, ram_oe} !== 4'b1010 || ram_addr !== 24'hFFFFFF || ram_data !== 16'h1234) begin
            errors++;
            $display("FAIL p1wr_launch: got ctrl=%b addr=%h data=%h, required 1010/FFFFFF/1234",
                     {p1_gnt, p0_gnt, ram_we, ram_oe}, ram_addr, ram_data);
        end
        p1_req = 0;
        tick();
        checks++;
        if (ram_we !== 1'b0 || p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL p1wr_onecycle: got we=%b rvalid1=%b, required 0/0", ram_we, p1_rvalid);
        end
        p0_req = 1; p0_we = 0; p0_addr = 24'hFFFFFF;
        tick();
        p0_req = 0;
        tick();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL p1wr_readback: got rvalid=%b rdata=%h, required 1/1234", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_reset_abort;
        p1_req = 1; p1_we = 1; p1_addr = 24'h000010; p1_wdata = 16'hCAFE;
        tick();
        p1_req = 0;
        tick();
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        tick();
        checks++;
        if ({p0_gnt, ram_oe} !== 2'b11) begin
            errors++;
            $display("FAIL abort_setup: got gnt/oe=%b, required 11", {p0_gnt, ram_oe});
        end
        p0_req = 0;
        r = 1;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we, ram_oe} !== 6'b0 || ram_addr !== 24'h0 ||
            {p0_rdata, p1_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL abort_clear: got ctrl=%b addr=%h rdata=%h/%h, required 000000/000000/0000/0000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we, ram_oe}, ram_addr, p0_rdata, p1_rdata);
        end
        r = 0;
        tick();
        checks++;
        if ({p0_rvalid, ram_we, ram_oe} !== 3'b000) begin
            errors++;
            $display("FAIL abort_late: got rvalid/we/oe=%b, required 000", {p0_rvalid, ram_we, ram_oe});
        end
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        tick();
        p0_req = 0;
        tick();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL abort_ramclr: got rvalid=%b rdata=%h, required 1/0000", p0_rvalid, p0_rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_simul_read();
        test_round_robin();
        test_p1_write_max();
        test_reset_abort();
        tick();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: address width of the RAM and of both request ports.
REQ-002 SHALL have parameter DATA_W, default 16: data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port r  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports p0_req/p1_req  input  1  request; held high until the matching grant.
REQ-006 SHALL have ports p0_we/p1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports p0_addr/p1_addr  input  ADDR_W  word address.
REQ-008 SHALL have ports p0_wdata/p1_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports p0_gnt/p1_gnt  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports p0_rvalid/p1_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports p0_rdata/p1_rdata  output  DATA_W  read data; holds its value until the next read completes.
REQ-012 SHALL have ports ram_we, ram_oe  output  1  RAM write and output enables.
REQ-013 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-014 SHALL have port ram_data  inout  DATA_W  RAM data bus; driven only while ram_we=1, otherwise high-Z.

Function
REQ-015 SHALL implement an FSM with states IDLE and ACCESS.
REQ-016 SHALL, in IDLE with any req high at the rising edge, select a winner, register ram_addr, ram_we/ram_oe and the write data, pulse the winner's gnt for the next cycle, and enter ACCESS.
REQ-017 SHALL, in ACCESS, hold ram_oe=1 for a read or ram_we=1 with ram_data driven for a write for exactly one cycle, then return to IDLE.
REQ-018 SHALL capture ram_data into the winner's rdata at the edge ending a read ACCESS and pulse that port's rvalid in the following cycle; a read takes 2 cycles from the req-sampling edge to rvalid.
REQ-019 SHALL never assert ram_we and ram_oe together, and SHALL never drive ram_data while ram_oe=1.
REQ-020 SHALL arbitrate simultaneous requests round-robin: the port not granted last wins.
REQ-021 SHALL ignore req while in ACCESS; the earliest next grant is from the following IDLE, giving a peak throughput of one access per 2 cycles.
REQ-022 SHALL let a continuously requesting single port win every arbitration.
REQ-023 SHALL never assert both gnt outputs in the same cycle, nor both rvalid outputs in the same cycle.

Reset
REQ-024 SHALL, while r=1 at a rising edge, set state=IDLE, all gnt/rvalid/ram_we/ram_oe=0, ram_addr=0, both rdata=0, ram_data high-Z, and last-granted=port 1, so port 0 wins the first tie.
REQ-025 SHALL abort an in-flight ACCESS on r=1: no rvalid pulse and no further RAM enable after that edge.
REQ-026 SHALL drive r unchanged to the RAM reset, so both blocks clear on the same edge.

Configuration
REQ-027 SHALL, when MEM_ARBITER_FIXED_PRIO_EN is defined, grant port 0 on every tie and not update the last-granted pointer.
REQ-028 SHALL, when MEM_ARBITER_FIXED_PRIO_EN is undefined, use the round-robin rule of REQ-020.

Structure
REQ-029 SHALL place the state enum (IDLE, ACCESS), ADDR_W/DATA_W defaults and the port-index constants in package mem_arbiter_pkg.
REQ-030 SHALL implement winner selection and the last-granted pointer in sub-module mem_arbiter_rr.

Verification
REQ-031 Bench SHALL cover: p0 write addr 0x000010, data 0xBEEF, then p0 read of 0x000010 -> p0_gnt pulse, p0_rvalid 2 cycles after the req-sampling edge, rdata=0xBEEF.
REQ-032 Bench SHALL cover: p0 and p1 reading together from reset -> p0 granted first, p1 granted 2 cycles later, no overlapping gnt.
REQ-033 Bench SHALL cover: both ports requesting continuously for 8 grants -> alternation p0,p1,p0,... (fixed-prio build: p0 on every grant, p1 starved).
REQ-034 Bench SHALL cover: p1 write of 0x1234 to 0xFFFFFF -> ram_we high for 1 cycle, ram_addr=0xFFFFFF, p0 reads back 0x1234.
REQ-035 Bench SHALL cover: r asserted during a read ACCESS -> no rvalid, all outputs zero next cycle, RAM word at 0x000010 reads back 0x0000.
REQ-036 Bench SHALL check on every cycle: ram_we and ram_oe never both high, and ram_data is high-Z whenever ram_we=0.
